cmd_frame_parser: RTL

- Upstream neighbour of the VDAS control FSM. Consumes raw bytes from the UART receiver and assembles them into validated command frames.
- Hands each validated command to control with a valid/ack handshake. Control's RECV state waits on cmd_valid; cmd_exec selects EXEC vs SEND.
- Payload is buffered internally. Control reads it through a random-access read port.

---
 rtl/vdas_pkg.sv | 23 ++
 rtl/cmd_frame_parser_if.sv | 32 +++
 rtl/cmd_payload_ram.sv | 34 +++
 rtl/cmd_frame_parser.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/vdas_pkg.sv
// Shared VDAS definitions: frame marker, parser state encoding, opcode fields.
// Used by the command frame parser and by the control FSM.
package vdas_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         OPC_EXEC_BIT  = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPC,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_HOLD
    } parser_state_t;

    // States where the inter-byte timeout is armed
    function automatic logic in_frame(parser_state_t s);
        return (s == ST_OPC) || (s == ST_LEN) ||
               (s == ST_PAYLOAD) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/cmd_frame_parser_if.sv
// Byte stream, command handshake and payload read port of the frame parser.
// slave = parser side, master = UART/control side.
interface cmd_frame_parser_if #(
    parameter int AW = 4
);
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          cmd_valid;
    logic          cmd_ack;
    logic [7:0]    cmd_opcode;
    logic [7:0]    cmd_len;
    logic          cmd_exec;
    logic [AW-1:0] pl_addr;
    logic [7:0]    pl_data;
    logic          err_chk;
    logic          err_len;
    logic          err_timeout;

    modport slave (
        input  in_data, in_valid, cmd_ack, pl_addr,
        output in_ready, cmd_valid, cmd_opcode, cmd_len, cmd_exec,
        output pl_data, err_chk, err_len, err_timeout
    );

    modport master (
        output in_data, in_valid, cmd_ack, pl_addr,
        input  in_ready, cmd_valid, cmd_opcode, cmd_len, cmd_exec,
        input  pl_data, err_chk, err_len, err_timeout
    );

endinterface

// File: rtl/cmd_payload_ram.sv
// Payload buffer: one write port, one registered read port.
// Array contents are never cleared; only the read register resets.
module cmd_payload_ram #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [2**AW];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cmd_frame_parser.sv
// Assembles UART bytes into checked command frames (SYNC OPC LEN PAYLOAD CHK)
// and holds each valid command for control until acknowledged.
module cmd_frame_parser
    import vdas_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         MAX_PAYLOAD = 16,
    parameter int         TIMEOUT_CYC = 50000,
    parameter int         AW          = 4
) (
    input  logic                clk,
    input  logic                rst,
    cmd_frame_parser_if.slave   bus
);

    localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    MAXP     = 8'(MAX_PAYLOAD);

    parser_state_t r_state;
    logic          r_in_ready;
    logic          r_cmd_valid;
    logic [7:0]    r_opcode;
    logic          r_exec;
    logic [7:0]    r_len;
    logic [7:0]    r_xor;
    logic [7:0]    r_idx;
    logic [TW-1:0] r_tmo;
    logic          r_err_chk;
    logic          r_err_len;
    logic          r_err_tmo;

    logic          w_acc;
    logic [7:0]    w_byte;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [7:0]    w_rdata;

    assign w_acc   = bus.in_valid & r_in_ready;
    assign w_byte  = bus.in_data;
    assign w_we    = w_acc & (r_state == ST_PAYLOAD);
    assign w_waddr = r_idx[AW-1:0];

    cmd_payload_ram #(
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_byte),
        .i_raddr (bus.pl_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_cmd_valid <= 1'b0;
            r_opcode    <= '0;
            r_exec      <= 1'b0;
            r_len       <= '0;
            r_xor       <= '0;
            r_idx       <= '0;
            r_tmo       <= '0;
            r_err_chk   <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_tmo   <= 1'b0;
        end else begin
            r_err_chk <= 1'b0;
            r_err_len <= 1'b0;
            r_err_tmo <= 1'b0;

            // A byte in the expiry cycle takes priority over the timeout
            if (in_frame(r_state) && !w_acc) begin
                if (r_tmo == TMO_LAST) begin
                    r_err_tmo <= 1'b1;
                    r_state   <= ST_IDLE;
                    r_tmo     <= '0;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end else begin
                r_tmo <= '0;
            end

            if (w_acc) begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_byte == SYNC_BYTE) begin
                            r_state <= ST_OPC;
                        end
                    end
                    ST_OPC: begin
                        r_opcode <= w_byte;
                        r_exec   <= w_byte[OPC_EXEC_BIT];
                        r_xor    <= w_byte;
                        r_state  <= ST_LEN;
                    end
                    ST_LEN: begin
                        r_len <= w_byte;
                        r_xor <= r_xor ^ w_byte;
                        r_idx <= '0;
                        if (w_byte > MAXP) begin
                            r_err_len <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else if (w_byte == 8'd0) begin
                            r_state <= ST_CHK;
                        end else begin
                            r_state <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        r_xor <= r_xor ^ w_byte;
                        r_idx <= r_idx + 8'd1;
                        if ((r_idx + 8'd1) == r_len) begin
                            r_state <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        if (w_byte == r_xor) begin
                            r_state     <= ST_HOLD;
                            r_cmd_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                        end else begin
                            r_err_chk <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                    end
                    ST_HOLD: begin
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end

            if ((r_state == ST_HOLD) && bus.cmd_ack) begin
                r_cmd_valid <= 1'b0;
                r_in_ready  <= 1'b1;
                r_state     <= ST_IDLE;
            end
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.cmd_valid   = r_cmd_valid;
    assign bus.cmd_opcode  = r_opcode;
    assign bus.cmd_len     = r_len;
    assign bus.cmd_exec    = r_exec;
    assign bus.pl_data     = w_rdata;
    assign bus.err_chk     = r_err_chk;
    assign bus.err_len     = r_err_len;
    assign bus.err_timeout = r_err_tmo;

endmodule
